// File: rtl/muldiv.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle, then a
// sign/special-case fix-up cycle, giving a fixed WIDTH+2 cycle latency.
module muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg;
    logic [2:0]       op_reg;
    logic [WIDTH-1:0] hi_reg, lo_reg, b_reg, result_reg;
    logic             neg_reg;

    logic             accept;
    logic             a_signed, b_signed, a_neg, b_neg, neg_next;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix, fix_result;

    assign accept = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign busy   = (state_reg == RUN) || (state_reg == FIX);
    assign done   = (state_reg == DONE);
    assign result = result_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (count_reg == '0) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = accept ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand signedness per funct3; MUL's low half is sign-agnostic.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (op)
            3'd1, 3'd4, 3'd6: begin a_signed = 1'b1; b_signed = 1'b1; end
            3'd2:             a_signed = 1'b1;
            default:          ;
        endcase
        a_neg = a_signed & src_a[WIDTH-1];
        b_neg = b_signed & src_b[WIDTH-1];
        a_mag = a_neg ? -src_a : src_a;
        b_mag = b_neg ? -src_b : src_b;
        case (op)
            3'd1:    neg_next = a_neg ^ b_neg;
            3'd2:    neg_next = a_neg;
            3'd4:    neg_next = (a_neg ^ b_neg) && (src_b != '0);
            3'd6:    neg_next = a_neg;
            default: neg_next = 1'b0;
        endcase
    end

    // Multiply: {hi,lo} shifts right, adding the multiplicand on lo[0].
    // Divide: {hi,lo} shifts left, restoring subtract into hi, quotient into lo.
    always_comb begin
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
        div_shift = {hi_reg, lo_reg[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_reg};
    end

    always_comb begin
        prod_fix = neg_reg ? -{hi_reg, lo_reg} : {hi_reg, lo_reg};
        quo_fix  = neg_reg ? -lo_reg : lo_reg;
        rem_fix  = neg_reg ? -hi_reg : hi_reg;
        case (op_reg)
            3'd0:             fix_result = prod_fix[WIDTH-1:0];
            3'd1, 3'd2, 3'd3: fix_result = prod_fix[2*WIDTH-1:WIDTH];
            3'd4, 3'd5:       fix_result = (b_reg == '0) ? '1 : quo_fix;
            default:          fix_result = rem_fix;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg  <= '0;
            op_reg     <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            b_reg      <= '0;
            neg_reg    <= 1'b0;
            result_reg <= '0;
        end else begin
            if (accept) begin
                count_reg <= CW'(WIDTH - 1);
                op_reg    <= op;
                neg_reg   <= neg_next;
                hi_reg    <= '0;
                lo_reg    <= op[2] ? a_mag : b_mag;
                b_reg     <= op[2] ? b_mag : a_mag;
            end else if (state_reg == RUN) begin
                if (count_reg != '0) count_reg <= count_reg - CW'(1);
                if (op_reg[2]) begin
                    if (!div_diff[WIDTH]) begin
                        hi_reg <= div_diff[WIDTH-1:0];
                        lo_reg <= {lo_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_reg <= div_shift[WIDTH-1:0];
                        lo_reg <= {lo_reg[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    hi_reg <= mul_sum[WIDTH:1];
                    lo_reg <= {mul_sum[0], lo_reg[WIDTH-1:1]};
                end
            end
            if (state_reg == FIX) result_reg <= fix_result;
        end
    end
endmodule
